pipelined_adder: RTL and testbench

//  Parametrised, pipelined add/subtract unit. It is the sequential successor to the

---
 rtl/pipelined_adder.sv | 126 ++++++++++++
 tb/tb_pipelined_adder.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_adder.sv
// Pipelined add/subtract unit.
// The WIDTH-bit operation is cut into STAGES segments of SEG bits. Stage k adds
// segment k. It takes the carry out of stage k-1, so each clock covers only one
// SEG-bit add.
// Every stage register holds four things:
//   - the operand bits not yet summed (skew)
//   - the sum bits finished so far
//   - the carry out of its segment
//   - a valid bit
// The whole pipe advances together on one enable. That enable is low only
// when a result is waiting and the consumer refuses it.
//
// Handshake: a beat moves across an interface on a rising edge when valid and
// ready are both high on that side. valid never depends on ready. in_ready
// depends combinationally on out_valid/out_ready. A result presented with
// out_ready=0 holds its data until it is taken.
//
// Legal parameters are STAGES >= 1 and WIDTH divisible by STAGES.
module pipelined_adder #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int SEG  = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;

  // Stage registers
  logic             v_q [STAGES];
  logic [WIDTH-1:0] a_q [STAGES];
  logic [WIDTH-1:0] b_q [STAGES];
  logic [WIDTH-1:0] s_q [STAGES];
  logic             c_q [STAGES];
  logic             ovf_q;

  // Values presented to each stage register
  logic             v_d [STAGES];
  logic [WIDTH-1:0] a_d [STAGES];
  logic [WIDTH-1:0] b_d [STAGES];
  logic [WIDTH-1:0] s_in [STAGES];
  logic             c_in [STAGES];
  logic [WIDTH-1:0] s_d [STAGES];
  logic             c_d [STAGES];
  logic [SEG:0]     seg_sum [STAGES];
  logic             ovf_d;
  logic             msb_cin;
  logic             adv;

  // The whole pipe moves when the output slot is empty or is being drained.
  assign adv      = !out_valid | out_ready;
  assign in_ready = adv;

  // Stage inputs: stage 0 takes the port beat, with B inverted and the carry
  // forced to 1 for subtract. Every later stage takes its predecessor's register.
  always_comb begin
    v_d[0]  = in_valid;
    a_d[0]  = in_a;
    b_d[0]  = in_sub ? ~in_b : in_b;
    c_in[0] = in_sub ? 1'b1 : in_cin;
    s_in[0] = '0;
    for (int k = 1; k < STAGES; k++) begin
      v_d[k]  = v_q[k-1];
      a_d[k]  = a_q[k-1];
      b_d[k]  = b_q[k-1];
      c_in[k] = c_q[k-1];
      s_in[k] = s_q[k-1];
    end
  end

  // Each stage sums its own segment into the partial result. The MSB stage
  // also forms signed overflow: carry into the MSB XOR carry out of the MSB.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      seg_sum[k] = {1'b0, a_d[k][k*SEG +: SEG]}
                 + {1'b0, b_d[k][k*SEG +: SEG]}
                 + {{SEG{1'b0}}, c_in[k]};
      s_d[k]               = s_in[k];
      s_d[k][k*SEG +: SEG] = seg_sum[k][SEG-1:0];
      c_d[k]               = seg_sum[k][SEG];
    end
    msb_cin = a_d[LAST][WIDTH-1] ^ b_d[LAST][WIDTH-1] ^ seg_sum[LAST][SEG-1];
    ovf_d   = msb_cin ^ seg_sum[LAST][SEG];
  end

  // Pipeline registers: cleared on reset, shift together on adv, else hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k] <= 1'b0;
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
        c_q[k] <= 1'b0;
      end
      ovf_q <= 1'b0;
    end else if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k] <= v_d[k];
        a_q[k] <= a_d[k];
        b_q[k] <= b_d[k];
        s_q[k] <= s_d[k];
        c_q[k] <= c_d[k];
      end
      ovf_q <= ovf_d;
    end
  end

  assign out_valid = v_q[LAST];
  assign out_sum   = s_q[LAST];
  assign out_cout  = c_q[LAST];
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder (WIDTH=8, STAGES=2).
// The reference model works in plain integers: an unsigned sum for sum/cout
// and a signed sum with a range test for overflow. Expected results queue in
// acceptance order and are popped on every output transfer.
module tb_pipelined_adder;

  localparam int W = 8;
  localparam int S = 2;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         in_cin = 1'b0;
  logic         in_sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         out_ovf;

  always #5 clk = ~clk;

  pipelined_adder #(.WIDTH(W), .STAGES(S)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf)
  );

  // ---------------- scoreboard state ----------------
  int             n_checks = 0;
  int             n_fail   = 0;
  logic [W+1:0]   exp_q[$];
  int             ready_mode = 0;  // 0: always ready, 1: random, 2: stalled
  logic           hold_valid = 1'b0;
  logic [W+1:0]   hold_val   = '0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: {ovf, cout, sum} from integer arithmetic.
  function automatic logic [W+1:0] ref_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic cin, input logic sub);
    int ua, ub, c, total, sa, sb, st;
    logic [W-1:0] s;
    logic co, ov;
    ua    = int'(a);
    ub    = sub ? ((1 << W) - 1 - int'(b)) : int'(b);
    c     = sub ? 1 : int'(cin);
    total = ua + ub + c;
    s     = total[W-1:0];
    co    = (total >= (1 << W));
    sa    = (ua >= (1 << (W-1))) ? ua - (1 << W) : ua;
    sb    = (ub >= (1 << (W-1))) ? ub - (1 << W) : ub;
    st    = sa + sb + c;
    ov    = (st > (1 << (W-1)) - 1) || (st < -(1 << (W-1)));
    return {ov, co, s};
  endfunction

  // Consumer readiness pattern
  always @(negedge clk) begin
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom_range(0, 3) != 0);
      default: out_ready = 1'b0;
    endcase
  end

  // Monitor: samples mid-cycle, for the transfers at the coming rising edge.
  always @(negedge clk) begin
    #2;
    if (rst) begin
      hold_valid = 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check_val("out_unexpected", 32'd1, 32'd0);
        else check_val("out_beat", 32'({out_ovf, out_cout, out_sum}), 32'(exp_q.pop_front()));
      end
      if (out_valid && !out_ready) begin
        check_val("stall_in_ready", 32'(in_ready), 32'd0);
        if (hold_valid) check_val("stall_hold", 32'({out_ovf, out_cout, out_sum}), 32'(hold_val));
        hold_valid = 1'b1;
        hold_val   = {out_ovf, out_cout, out_sum};
      end else begin
        hold_valid = 1'b0;
      end
      if (in_valid && in_ready) exp_q.push_back(ref_model(in_a, in_b, in_cin, in_sub));
    end
  end

  // ---------------- driver tasks ----------------
  // Presents one beat from a falling edge and keeps it until it is accepted.
  task automatic drive_beat(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic cin, input logic sub, output int waited);
    waited = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_a = a; in_b = b; in_cin = cin; in_sub = sub;
    #1;
    while (!in_ready && waited < 100) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (waited >= 100) check_val("accept_timeout", 32'd1, 32'd0);
  endtask

  // Idle cycles with junk on the operand pins.
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_a = W'($urandom); in_b = W'($urandom);
      in_cin = 1'($urandom); in_sub = 1'($urandom);
    end
  endtask

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return {1'b0, {(W-1){1'b1}}};
      2: return {1'b1, {(W-1){1'b0}}};
      3: return '1;
      default: return W'($urandom);
    endcase
  endfunction

  // ---------------- main sequence ----------------
  int w;

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    #3;
    check_val("rst_out_valid", 32'(out_valid), 32'd0);
    check_val("rst_out_sum",   32'(out_sum),   32'd0);
    check_val("rst_out_cout",  32'(out_cout),  32'd0);
    check_val("rst_out_ovf",   32'(out_ovf),   32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_val("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Add, carry-in, signed overflow, subtract
    drive_beat(8'h0F, 8'h01, 1'b0, 1'b0, w);
    drive_beat(8'hFF, 8'h01, 1'b0, 1'b0, w);
    drive_beat(8'h7F, 8'h00, 1'b1, 1'b0, w);
    drive_beat(8'h80, 8'h80, 1'b0, 1'b0, w);
    drive_beat(8'h05, 8'h07, 1'b1, 1'b1, w);
    drive_beat(8'h07, 8'h05, 1'b0, 1'b1, w);
    idle(4);

    // Latency: one beat into an empty pipe
    @(negedge clk);
    in_valid = 1'b1; in_a = 8'h21; in_b = 8'h12; in_cin = 1'b0; in_sub = 1'b0;
    for (int i = 0; i < S - 1; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      #3;
      check_val("lat_early", 32'(out_valid), 32'd0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    #3;
    check_val("lat_due", 32'(out_valid), 32'd1);
    idle(3);

    // Streaming: 16 back-to-back beats, none may wait
    for (int i = 0; i < 16; i++) begin
      drive_beat(W'(i), W'(2 * i), 1'b0, 1'b0, w);
      check_val("stream_no_wait", 32'(w), 32'd0);
    end
    idle(4);
    check_val("stream_drained", 32'(exp_q.size()), 32'd0);

    // Backpressure: stall a full pipe for several cycles, then release
    ready_mode = 2;
    fork
      begin
        repeat (8) @(negedge clk);
        ready_mode = 0;
      end
      begin
        for (int i = 0; i < 5; i++) drive_beat(W'(8'h30 + i), W'(8'h50 + i), 1'b1, 1'b0, w);
      end
    join
    idle(5);
    check_val("bp_drained", 32'(exp_q.size()), 32'd0);

    // Random traffic with random backpressure
    ready_mode = 1;
    repeat (200) begin
      drive_beat(pick_operand(), pick_operand(), 1'($urandom), ($urandom_range(0, 3) == 0), w);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    idle(1);
    ready_mode = 0;
    idle(6);
    check_val("rand_drained", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset in the middle of a stream
    drive_beat(8'h11, 8'h22, 1'b0, 1'b0, w);
    drive_beat(8'h33, 8'h44, 1'b0, 1'b0, w);
    @(posedge clk);
    #3;
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    check_val("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check_val("mid_rst_out_sum",   32'(out_sum),   32'd0);
    check_val("mid_rst_out_cout",  32'(out_cout),  32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check_val("mid_rst_in_ready", 32'(in_ready), 32'd1);
    drive_beat(8'h40, 8'h02, 1'b0, 1'b0, w);
    idle(5);

    // Final drain
    w = 0;
    while ((exp_q.size() != 0 || out_valid) && w < 50) begin
      @(negedge clk);
      w++;
    end
    check_val("final_drain", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
